// File: rtl/adder_slice_seq_if.sv
// Operand/result handshake bundle for the slice-serial adder.
// The master side is the producer/consumer pair; the slave side is the sequencer.
interface adder_slice_seq_if #(
    parameter int DATA_W  = 64,
    parameter int SLICE_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  cout,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output cout,
        output busy
    );
endinterface

// File: rtl/adder_slice_seq.sv
// Slice-serial adder: one DATA_W-bit addition performed SLICE_W bits per clock
// through a single slice adder, with the inter-slice carry held in a register.
// All handshake outputs are registered and derived from the next state so they
// line up exactly with the state register.
module adder_slice_seq #(
    parameter int DATA_W  = 64,
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    adder_slice_seq_if.slave  bus
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic [DATA_W-1:0]  a_r;
    logic [DATA_W-1:0]  b_r;
    logic [DATA_W-1:0]  sum_r;
    logic               carry_r;
    logic               cout_r;
    logic [IDX_W-1:0]   idx_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               accept_s;
    logic               last_slice_s;
    logic [SLICE_W-1:0] a_slices_s [NSLICE];
    logic [SLICE_W-1:0] b_slices_s [NSLICE];
    logic [SLICE_W-1:0] slice_a_s;
    logic [SLICE_W-1:0] slice_b_s;
    logic [SLICE_W:0]   slice_add_s;

    // An operation is taken only while idle; in_ready_r mirrors the IDLE state.
    assign accept_s     = bus.in_valid & in_ready_r;
    assign last_slice_s = (idx_r == LAST_IDX);

    // Select the operand slices addressed by idx_r and add them with the held carry.
    always_comb begin
        for (int i = 0; i < NSLICE; i++) begin
            a_slices_s[i] = a_r[i*SLICE_W +: SLICE_W];
            b_slices_s[i] = b_r[i*SLICE_W +: SLICE_W];
        end
        slice_a_s   = a_slices_s[idx_r];
        slice_b_s   = b_slices_s[idx_r];
        slice_add_s = {1'b0, slice_a_s} + {1'b0, slice_b_s} + {{SLICE_W{1'b0}}, carry_r};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last slice,
    // DONE -> IDLE on the output handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_slice_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Registered handshake/status outputs, computed from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
            busy_r      <= (state_next_s != ST_IDLE);
        end
    end

    // Datapath: latch operands on accept, then write one sum slice per RUN cycle.
    // Slices not yet rewritten keep the previous result until overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r     <= {DATA_W{1'b0}};
            b_r     <= {DATA_W{1'b0}};
            sum_r   <= {DATA_W{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        carry_r <= bus.cin;
                        idx_r   <= {IDX_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx_r == IDX_W'(i)) begin
                            sum_r[i*SLICE_W +: SLICE_W] <= slice_add_s[SLICE_W-1:0];
                        end
                    end
                    carry_r <= slice_add_s[SLICE_W];
                    if (last_slice_s) begin
                        cout_r <= slice_add_s[SLICE_W];
                        idx_r  <= {IDX_W{1'b0}};
                    end else begin
                        idx_r  <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    carry_r <= carry_r;
                end
                default: begin
                    idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
endmodule

// File: tb/tb_adder_slice_seq.sv
// Self-checking bench for adder_slice_seq: table-driven single operations,
// stall / reset corner cases, and a random back-to-back stream, all checked
// through a scoreboard queue of expected {cout, sum}.
module tb_adder_slice_seq;
    localparam int DATA_W  = 64;
    localparam int SLICE_W = 8;
    localparam int NSLICE  = DATA_W / SLICE_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    adder_slice_seq_if #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) bus ();

    adder_slice_seq #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t        vecs [7];
    logic [64:0] sb_q [$];
    logic [63:0] exp_sum_drv;
    logic        exp_cout_drv;
    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Independent reference: full-width add with one extra bit for the carry.
    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic cin);
        ref_add = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    endfunction

    // One clock: record handshakes seen before the edge, update the scoreboard after it.
    task automatic tick(output bit acc, output bit ho);
        logic [63:0] s;
        logic        c;
        logic [64:0] e;
        bit          rst_pre;
        acc     = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1) && !reset;
        ho      = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1) && !reset;
        rst_pre = reset;
        s = bus.sum;
        c = bus.cout;
        @(posedge clk);
        #1;
        cycle++;
        if (rst_pre) sb_q.delete();
        if (acc) sb_q.push_back({exp_cout_drv, exp_sum_drv});
        if (ho) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_sum", s, e[63:0]);
                check("sb_cout", {63'd0, c}, {63'd0, e[64]});
            end
        end
    endtask

    task automatic tick1();
        bit acc, ho;
        tick(acc, ho);
    endtask

    task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic cin,
                            input logic [63:0] es, input logic ec);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        exp_sum_drv  = es;
        exp_cout_drv = ec;
        bus.in_valid = 1'b1;
    endtask

    // Wait (bounded) for out_valid; returns the number of clocks waited and whether in_ready stayed low.
    task automatic wait_out(output int n, output bit rdy_low);
        n = 0;
        rdy_low = 1'b1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
            tick1();
            n++;
        end
        if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
    endtask

    initial begin
        bit          acc, ho;
        int          n;
        bit          rdy_low;
        bit          stable;
        logic [64:0] r;
        int          last_ho;
        int          results;

        vecs[0] = '{64'd1, 64'd2, 1'b0, 64'd3, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1};
        vecs[2] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'd0, 1'b1};
        vecs[3] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[4] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[6] = '{64'h8000_0000_0000_00FF, 64'h8000_0000_0000_0001, 1'b0, 64'h0000_0000_0000_0100, 1'b1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 64'd0;
        bus.b         = 64'd0;
        bus.cin       = 1'b0;
        exp_sum_drv   = 64'd0;
        exp_cout_drv  = 1'b0;

        // Reset state.
        reset = 1'b1;
        tick1();
        tick1();
        reset = 1'b0;
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_busy",      {63'd0, bus.busy},      64'd0);
        check("rst_sum",       bus.sum,                64'd0);
        check("rst_cout",      {63'd0, bus.cout},      64'd0);

        // Table-driven single operations.
        for (int i = 0; i < 7; i++) begin
            drive_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout);
            tick(acc, ho);
            bus.in_valid = 1'b0;
            check("vec_accept", {63'd0, acc}, 64'd1);
            check("vec_busy", {63'd0, bus.busy}, 64'd1);
            wait_out(n, rdy_low);
            check("vec_latency", 64'(n), 64'(NSLICE));
            check("vec_in_ready_low", {63'd0, rdy_low}, 64'd1);
            check("vec_sum_direct", bus.sum, vecs[i].exp_sum);
            bus.out_ready = 1'b1;
            tick(acc, ho);
            bus.out_ready = 1'b0;
            check("vec_handshake", {63'd0, ho}, 64'd1);
            check("vec_idle_ready", {63'd0, bus.in_ready}, 64'd1);
            check("vec_idle_valid", {63'd0, bus.out_valid}, 64'd0);
        end

        // Stall in DONE for 5 cycles with in_valid held high.
        r = ref_add(64'd5, 64'd7, 1'b0);
        drive_op(64'd5, 64'd7, 1'b0, r[63:0], r[64]);
        tick1();
        wait_out(n, rdy_low);
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(acc, ho);
            if (acc || ho) stable = 1'b0;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
            if (bus.sum !== 64'd12 || bus.cout !== 1'b0) stable = 1'b0;
        end
        check("stall_stable", {63'd0, stable}, 64'd1);
        bus.out_ready = 1'b1;
        tick(acc, ho);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("stall_release", {63'd0, ho}, 64'd1);
        check("stall_to_idle", {63'd0, bus.in_ready}, 64'd1);

        // Reset after the third RUN cycle discards the operation.
        drive_op(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1, 64'd0, 1'b0);
        tick1();
        bus.in_valid = 1'b0;
        tick1();
        tick1();
        tick1();
        reset = 1'b1;
        tick1();
        reset = 1'b0;
        check("mid_rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_busy",      {63'd0, bus.busy},      64'd0);
        check("mid_rst_sum",       bus.sum,                64'd0);
        check("mid_rst_cout",      {63'd0, bus.cout},      64'd0);
        bus.out_ready = 1'b1;
        stable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick(acc, ho);
            if (bus.out_valid !== 1'b0 || ho) stable = 1'b0;
        end
        check("mid_rst_no_result", {63'd0, stable}, 64'd1);

        // Back-to-back random stream: one result every NSLICE+2 cycles.
        r = ref_add({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        bus.a   = {$urandom, $urandom};
        bus.b   = {$urandom, $urandom};
        bus.cin = 1'($urandom_range(0, 1));
        r = ref_add(bus.a, bus.b, bus.cin);
        exp_sum_drv  = r[63:0];
        exp_cout_drv = r[64];
        bus.in_valid = 1'b1;
        last_ho = -1;
        results = 0;
        for (int k = 0; k < 90 && results < 8; k++) begin
            tick(acc, ho);
            if (acc) begin
                bus.a   = {$urandom, $urandom};
                bus.b   = {$urandom, $urandom};
                bus.cin = 1'($urandom_range(0, 1));
                r = ref_add(bus.a, bus.b, bus.cin);
                exp_sum_drv  = r[63:0];
                exp_cout_drv = r[64];
            end
            if (ho) begin
                if (last_ho >= 0) check("stream_interval", 64'(cycle - last_ho), 64'(NSLICE + 2));
                last_ho = cycle;
                results++;
            end
        end
        check("stream_results", 64'(results), 64'd8);

        // Drain whatever is still in flight.
        bus.in_valid = 1'b0;
        for (int k = 0; k < 30 && sb_q.size() > 0; k++) tick1();
        check("drain_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
